// File: rtl/ctrl_noc_extra_hdr_arb_pkg.sv
// ctrl_noc_extra_hdr_arb_pkg: shared ctrl NoC arbitration types and message-length helpers
`ifndef CTRL_NOC1_DATA_W
`define CTRL_NOC1_DATA_W 64
`endif
package ctrl_noc_extra_hdr_arb_pkg;
  localparam int CTRL_NOC1_DATA_W = `CTRL_NOC1_DATA_W;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;
  function automatic int extra_flits(input int extra_w);
    return (extra_w + CTRL_NOC1_DATA_W - 1) / CTRL_NOC1_DATA_W;
  endfunction
  function automatic int msg_flits(input int extra_w);
    return 2 + extra_flits(extra_w);
  endfunction
endpackage

// File: rtl/ctrl_noc_extra_hdr_arb_rr_pick.sv
// rr_pick: first asserted request at or after ptr, scanning upward with wrap-around
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    found = |req;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
  end
endmodule

// File: rtl/ctrl_noc_extra_hdr_arb.sv
// ctrl_noc_extra_hdr_arb: round-robin merge of ctrl NoC sources, locked for whole fixed-length messages
module ctrl_noc_extra_hdr_arb
  import ctrl_noc_extra_hdr_arb_pkg::*;
#(
  parameter int NUM_SRCS = 4,
  parameter int EXTRA_W = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRCS-1:0]                  src_arb_val,
  input  logic [NUM_SRCS*CTRL_NOC1_DATA_W-1:0] src_arb_data,
  output logic [NUM_SRCS-1:0]                  arb_src_rdy,
  output logic                                 arb_dst_val,
  output logic [CTRL_NOC1_DATA_W-1:0]          arb_dst_data,
  input  logic                                 dst_arb_rdy,
  output logic [$clog2(NUM_SRCS)-1:0]          arb_grant_idx
);
  localparam int IW = $clog2(NUM_SRCS);
  localparam int DW = CTRL_NOC1_DATA_W;
  localparam int MSG = msg_flits(EXTRA_W);
  localparam int CW = $clog2(MSG + 1);
  arb_state_e state, state_n;
  logic [IW-1:0] rr_ptr, grant_reg, sel, pick_idx;
  logic [CW-1:0] flit_cnt;
  logic pick_found, xfer, last;
  rr_pick #(.N(NUM_SRCS), .IW(IW)) u_pick (
    .req(src_arb_val),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_reg <= '0;
      flit_cnt <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        grant_reg <= sel;
        flit_cnt <= (state == IDLE) ? CW'(1) : flit_cnt + CW'(1);
        if (state == LOCKED && last)
          rr_ptr <= (grant_reg == IW'(NUM_SRCS - 1)) ? '0 : grant_reg + IW'(1);
      end
    end
  end
  always_comb
    state_n = (state == IDLE) ? (xfer ? LOCKED : IDLE) : ((xfer && last) ? IDLE : LOCKED);
  // IDLE exposes the rr winner with zero latency; LOCKED pins the mux to the grantee
  always_comb begin
    sel = (state == LOCKED) ? grant_reg : pick_idx;
    arb_dst_val = (state == LOCKED) ? src_arb_val[grant_reg] : pick_found;
    arb_dst_data = src_arb_data[int'(sel)*DW +: DW];
    arb_src_rdy = ((state == LOCKED || pick_found) && dst_arb_rdy) ? NUM_SRCS'(1) << sel : '0;
    arb_grant_idx = (state == LOCKED || !pick_found) ? grant_reg : pick_idx;
    xfer = arb_dst_val && dst_arb_rdy;
    last = flit_cnt == CW'(MSG - 1);
  end
endmodule

// File: doc/ctrl_noc_extra_hdr_arb.md
CTRL_NOC_EXTRA_HDR_ARB -- requirements
Module: ctrl_noc_extra_hdr_arb

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 4, meaning the number of narrow ctrl NoC requesters (2..16).
REQ-002 SHALL have parameter EXTRA_W, default 64, meaning the extra-header bit width carried after the two header flits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port src_arb_val, input, NUM_SRCS, per-source flit valid.
REQ-006 SHALL have port src_arb_data, input, NUM_SRCS x `CTRL_NOC1_DATA_W, per-source flit.
REQ-007 SHALL have port arb_src_rdy, output, NUM_SRCS, per-source ready.
REQ-008 SHALL have port arb_dst_val, output, 1, merged flit valid toward the ctrl-to-data widener.
REQ-009 SHALL have port arb_dst_data, output, `CTRL_NOC1_DATA_W, merged flit.
REQ-010 SHALL have port dst_arb_rdy, input, 1, downstream ready.
REQ-011 SHALL have port arb_grant_idx, output, clog2(NUM_SRCS), index of the current or last winner, for debug.

Function
REQ-012 Message length SHALL be the constant MSG_FLITS = 2 + EXTRA_FLITS, with EXTRA_FLITS = ceil(EXTRA_W / `CTRL_NOC1_DATA_W); no header field is parsed.
REQ-013 The FSM SHALL have two states: IDLE (no message in progress) and LOCKED (a message is partially transferred).
REQ-014 In IDLE, the winner SHALL be the first asserted src_arb_val bit at or after rr_ptr, scanning upward with wrap-around.
REQ-015 In IDLE, the winner's flit SHALL drive arb_dst_val/arb_dst_data in the same cycle (zero-cycle arbitration latency).
REQ-016 A flit transfers iff arb_dst_val and dst_arb_rdy are both high; arb_src_rdy[i] SHALL equal dst_arb_rdy for the granted source only and 0 for all others.
REQ-017 On a transfer in IDLE, the winner SHALL be registered as grant_reg, flit_cnt SHALL be set to 1, and the FSM SHALL go to LOCKED; with no transfer it SHALL stay in IDLE and not register a grant.
REQ-018 In LOCKED, the mux SHALL select grant_reg only; other sources' valids SHALL be ignored and a deasserted grantee valid SHALL stall the output (no interleaving).
REQ-019 Each LOCKED transfer SHALL increment flit_cnt; the transfer with flit_cnt == MSG_FLITS-1 SHALL return the FSM to IDLE and set rr_ptr = (grant_reg + 1) mod NUM_SRCS.
REQ-020 A new message SHALL be arbitrated in the IDLE cycle immediately after the last flit, giving no bubble when requests are pending.
REQ-021 Data SHALL pass through combinationally without modification; the block SHALL NOT buffer flits.
REQ-022 arb_dst_val SHALL never depend on dst_arb_rdy.
REQ-023 With all src_arb_val low in IDLE, arb_dst_val SHALL be 0, arb_src_rdy SHALL be all 0, and rr_ptr SHALL hold.
REQ-024 If a single source is valid, it SHALL win regardless of rr_ptr.

Reset
REQ-025 rst SHALL set state to IDLE, rr_ptr to 0, grant_reg to 0, and flit_cnt to 0.
REQ-026 During and after reset, arb_dst_val SHALL be 0 until a source asserts valid, and arb_src_rdy SHALL be all 0.
REQ-027 Reset in LOCKED SHALL abandon the partial message; the downstream widener SHALL be reset by the same rst.

Structure
REQ-028 MSG_FLITS and EXTRA_FLITS computation helpers, and the IDLE/LOCKED state enum, SHALL live in a shared ctrl NoC arbitration package, beside beehive_ctrl_noc_msg.
REQ-029 The rotating priority pick SHALL be one sub-module, rr_pick (inputs: request vector, pointer; outputs: found, index), reusable by other NoC arbiters.
REQ-030 The target size is 150-250 RTL lines including the sub-module.

Verification (NUM_SRCS=4, EXTRA_W=64, `CTRL_NOC1_DATA_W=64, MSG_FLITS=3)
REQ-031 After reset, raise src 2 only with dst_arb_rdy=1 -> flits out on 3 consecutive cycles, starting the same cycle; arb_grant_idx=2; rr_ptr becomes 3.
REQ-032 Hold sources 0-3 all valid continuously -> message order 0,1,2,3,0, with 3 flits each and no idle cycles between messages.
REQ-033 With src 1 locked after 1 flit, drop src1 val for 4 cycles while src 0 is valid -> arb_dst_val=0 and src 0 is not granted; then src 1 finishes its 2 flits.
REQ-034 Toggle dst_arb_rdy randomly at 50% during 100 messages from random sources -> scoreboard shows per-source in-order, unbroken 3-flit groups and no lost or duplicated flits.
REQ-035 Assert rst in LOCKED after flit 2 -> the next cycle shows IDLE, rr_ptr=0, and the next message starts from the lowest valid index.
